// File: rtl/arrange_seq_if.sv
// Data-memory read port and arrange-stage control bundle driven by arrange_seq.
interface arrange_seq_if #(
  parameter int DM_ADDR = 8
);
  logic               dm_csb;
  logic               dm_oeb;
  logic [DM_ADDR-1:0] dm_addr;
  logic               arr_data_valid;
  logic [1:0]         arr_mode;
  logic [3:0]         arr_position;
  logic               arr_done;

  // Sequencer side: drives the memory read port and the arrange controls.
  modport master (
    output dm_csb, dm_oeb, dm_addr, arr_data_valid, arr_mode, arr_position,
    input  arr_done
  );

  // Memory / arrange side.
  modport slave (
    input  dm_csb, dm_oeb, dm_addr, arr_data_valid, arr_mode, arr_position,
    output arr_done
  );
endinterface

// File: rtl/arrange_seq.sv
// Sequencer for the arrange (sample re-ordering) stage: per frame position it
// reads one data-memory row, strobes arrange's data_valid, waits for done and
// steps position/address, with a timeout watchdog on each wait.
module arrange_seq #(
  parameter int DM_ADDR = 8,
  parameter int DM_LAT  = 1,
  parameter int TO_CYC  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_mode,
  input  logic [4:0]         cfg_npos,
  input  logic [DM_ADDR-1:0] cfg_base,
  arrange_seq_if.master      bus,
  output logic               busy,
  output logic               frame_done,
  output logic               err_timeout
);

  // Latency counter runs 0..DM_LAT-1; the wait timer runs 1..TO_CYC-1.
  localparam int LW = (DM_LAT > 1) ? $clog2(DM_LAT) : 1;
  localparam int TW = $clog2(TO_CYC);
  localparam logic [LW-1:0] LAT_LAST = LW'(DM_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_VALID, S_WAIT, S_ADV, S_SETTLE, S_FIN
  } state_t;

  state_t        state, next_state;
  logic [LW-1:0] lat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    last_pos;
  logic          start_ok;
  logic          tmo_fire;
  logic          csb_d, oeb_d, dv_d, fin_d, busy_d;

  // abort outranks a same-cycle start; the timer expiring loses to a same-cycle done.
  assign start_ok = (state == S_IDLE) && start && !abort;
  assign tmo_fire = (state == S_WAIT) && !bus.arr_done && (tmo_cnt == TMO_LAST) && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; abort forces IDLE from anywhere.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) next_state = S_RD;
        S_RD:     next_state = S_LAT;
        S_LAT:    if (lat_cnt == LAT_LAST) next_state = S_VALID;
        S_VALID:  next_state = S_WAIT;
        S_WAIT: begin
          if (bus.arr_done)
            next_state = (bus.arr_position == last_pos) ? S_FIN : S_ADV;
          else if (tmo_cnt == TMO_LAST)
            next_state = S_IDLE;
        end
        S_ADV:    next_state = S_SETTLE;
        S_SETTLE: next_state = S_RD;
        S_FIN:    next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, so the registered outputs line up with it.
  always_comb begin
    csb_d  = (next_state != S_RD);
    oeb_d  = !((next_state == S_RD) || (next_state == S_LAT));
    dv_d   = (next_state == S_VALID);
    fin_d  = (next_state == S_FIN);
    busy_d = (next_state != S_IDLE);
  end

  // Registered strobes, memory controls and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dm_csb         <= 1'b1;
      bus.dm_oeb         <= 1'b1;
      bus.arr_data_valid <= 1'b0;
      frame_done         <= 1'b0;
      busy               <= 1'b0;
      err_timeout        <= 1'b0;
    end else begin
      bus.dm_csb         <= csb_d;
      bus.dm_oeb         <= oeb_d;
      bus.arr_data_valid <= dv_d;
      frame_done         <= fin_d;
      busy               <= busy_d;
      if (start_ok)      err_timeout <= 1'b0;
      else if (tmo_fire) err_timeout <= 1'b1;
    end
  end

  // Frame configuration, position and row address; these only move on an
  // accepted start or on entry to ADV, so they are stable through LAT/VALID/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.arr_mode     <= 2'd0;
      bus.arr_position <= 4'd0;
      bus.dm_addr      <= '0;
      last_pos         <= 4'd0;
    end else if (start_ok) begin
      bus.arr_mode     <= cfg_mode;
      bus.arr_position <= 4'd0;
      bus.dm_addr      <= cfg_base;
      // 0 and 16 both truncate to 0 and wrap to 15; anything above 16 is clamped to 16.
      last_pos         <= (cfg_npos > 5'd16) ? 4'd15 : cfg_npos[3:0] - 4'd1;
    end else if (next_state == S_ADV) begin
      bus.arr_position <= bus.arr_position + 4'd1;
      bus.dm_addr      <= bus.dm_addr + DM_ADDR'(1);
    end
  end

  // Memory-latency counter and arr_done watchdog (counts cycles since data_valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_LAT) lat_cnt <= lat_cnt + LW'(1);
      else                lat_cnt <= '0;
      if (state == S_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      else                 tmo_cnt <= TW'(1);
    end
  end

endmodule

// File: tb/tb_arrange_seq.sv
// Self-checking bench for arrange_seq: a frame model predicts a time-stamped
// event stream into a scoreboard queue; a monitor turns observed output
// activity into events and compares them in order.
module tb_arrange_seq;

  localparam int DM_ADDR = 8;
  localparam int DM_LAT  = 2;
  localparam int TO_CYC  = 32;
  localparam int NEVER   = 1000;

  typedef enum int {
    EV_BUSY_RISE, EV_ERR_CLR, EV_MODE, EV_POS, EV_OE_ON, EV_READ,
    EV_OE_OFF, EV_VALID, EV_FIN, EV_ERR_SET, EV_BUSY_FALL
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, abort;
  logic [1:0]         cfg_mode;
  logic [4:0]         cfg_npos;
  logic [DM_ADDR-1:0] cfg_base;
  logic               busy, frame_done, err_timeout;

  arrange_seq_if #(.DM_ADDR(DM_ADDR)) bus ();

  arrange_seq #(.DM_ADDR(DM_ADDR), .DM_LAT(DM_LAT), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_mode    (cfg_mode),
    .cfg_npos    (cfg_npos),
    .cfg_base    (cfg_base),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  int   dq[$];
  bit   mon_en = 1'b0;

  // Reference state: what the DUT should currently be showing.
  logic [1:0] m_mode = 2'd0;
  int         m_pos  = 0;
  bit         m_err  = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({"unexpected ", kind.name(), " at cycle"}, cyc, -1);
      return;
    end
    e = exp_q.pop_front();
    check({"event kind (expected ", e.kind.name(), ")"}, int'(kind), int'(e.kind));
    if (kind == e.kind) begin
      check({kind.name(), " cycle"}, cyc, e.cyc);
      check({kind.name(), " value"}, val, e.val);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " dm_csb"},         int'(bus.dm_csb), 1);
    check({tag, " dm_oeb"},         int'(bus.dm_oeb), 1);
    check({tag, " arr_data_valid"}, int'(bus.arr_data_valid), 0);
    check({tag, " busy"},           int'(busy), 0);
    check({tag, " frame_done"},     int'(frame_done), 0);
  endtask

  // Arrange stand-in: answers each data_valid with a one-cycle done after the
  // delay queued for that position (NEVER = no answer).
  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && bus.arr_data_valid) begin
        if (dq.size() > 0) d = dq.pop_front();
        else               d = NEVER;
        if (d < NEVER) begin
          repeat (d) @(posedge clk);
          #1 bus.arr_done = 1'b1;
          @(posedge clk);
          #1 bus.arr_done = 1'b0;
        end
      end
    end
  end

  // Monitor: converts output activity into events, in a fixed per-cycle order.
  initial begin : monitor
    logic       p_busy, p_err, p_oeb;
    logic [1:0] p_mode;
    logic [3:0] p_pos;
    p_busy = 1'b0; p_err = 1'b0; p_oeb = 1'b1; p_mode = 2'd0; p_pos = 4'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !p_busy)               observe(EV_BUSY_RISE, 0);
        if (!err_timeout && p_err)         observe(EV_ERR_CLR, 0);
        if (bus.arr_mode != p_mode)        observe(EV_MODE, int'(bus.arr_mode));
        if (bus.arr_position != p_pos)     observe(EV_POS, int'(bus.arr_position));
        if (!bus.dm_oeb && p_oeb)          observe(EV_OE_ON, 0);
        if (!bus.dm_csb)                   observe(EV_READ, int'(bus.dm_addr));
        if (bus.dm_oeb && !p_oeb)          observe(EV_OE_OFF, 0);
        if (bus.arr_data_valid)
          observe(EV_VALID, int'(bus.arr_position) * 4 + int'(bus.arr_mode));
        if (frame_done)                    observe(EV_FIN, 0);
        if (err_timeout && !p_err)         observe(EV_ERR_SET, 0);
        if (!busy && p_busy)               observe(EV_BUSY_FALL, 0);
      end
      p_busy = busy; p_err = err_timeout; p_oeb = bus.dm_oeb;
      p_mode = bus.arr_mode; p_pos = bus.arr_position;
    end
  end

  // Issue one frame and predict its complete event stream. Each position costs
  // read(1) + latency(DM_LAT) + valid(1) + done delay, then ADV + SETTLE before
  // the next read. abort_k aborts in the cycle done arrives for that position;
  // poke re-pulses start with another mode while the first position waits.
  task automatic run_frame(input logic [1:0] mode, input logic [4:0] npos,
                           input logic [7:0] base, input int dly[16],
                           input int abort_k, input bit poke);
    int s, r, v, dc, n, end_cyc, abort_cyc, poke_cyc;
    n = (npos == 5'd0) ? 16 : int'(npos);
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; cfg_mode = mode; cfg_npos = npos; cfg_base = base;
    abort_cyc = -1; poke_cyc = -1; end_cyc = s + 1;

    push(EV_BUSY_RISE, s + 1, 0);
    if (m_err)          begin push(EV_ERR_CLR, s + 1, 0); m_err = 1'b0; end
    if (mode != m_mode) begin push(EV_MODE, s + 1, int'(mode)); m_mode = mode; end
    if (m_pos != 0)     begin push(EV_POS, s + 1, 0); m_pos = 0; end
    r = s + 1;
    for (int k = 0; k < n; k++) begin
      dq.push_back(dly[k]);
      push(EV_OE_ON, r, 0);
      push(EV_READ, r, (int'(base) + k) % 256);
      v = r + 1 + DM_LAT;
      push(EV_OE_OFF, v, 0);
      push(EV_VALID, v, k * 4 + int'(mode));
      if (k == 0 && poke) poke_cyc = v + 2;
      if (dly[k] >= TO_CYC) begin
        push(EV_ERR_SET, v + TO_CYC, 0);
        push(EV_BUSY_FALL, v + TO_CYC, 0);
        m_err = 1'b1;
        end_cyc = v + TO_CYC;
        break;
      end
      dc = v + dly[k];
      if (k == abort_k) begin
        abort_cyc = dc;
        push(EV_BUSY_FALL, dc + 1, 0);
        end_cyc = dc + 1;
        break;
      end
      if (k == n - 1) begin
        push(EV_FIN, dc + 1, 0);
        push(EV_BUSY_FALL, dc + 2, 0);
        end_cyc = dc + 2;
      end else begin
        push(EV_POS, dc + 1, k + 1);
        m_pos = k + 1;
        r = dc + 3;
      end
    end

    while (cyc < end_cyc + 4) begin
      @(posedge clk); #1;
      abort = (cyc == abort_cyc);
      if (cyc == poke_cyc) begin
        start = 1'b1; cfg_mode = ~mode;
      end else begin
        start = 1'b0;
      end
      if (cyc == s + 1) begin
        cfg_npos = 5'($urandom); cfg_base = 8'($urandom);
        cfg_mode = 2'($urandom);
      end
    end
    abort = 1'b0; start = 1'b0;
    check("events still pending after frame", exp_q.size(), 0);
    exp_q.delete();
    dq.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int d[16];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_mode = 2'd0; cfg_npos = 5'd0; cfg_base = '0;
    bus.arr_done = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset dm_addr",      int'(bus.dm_addr), 0);
    check("reset arr_mode",     int'(bus.arr_mode), 0);
    check("reset arr_position", int'(bus.arr_position), 0);
    check("reset err_timeout",  int'(err_timeout), 0);
    rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    // Single position, done 5 cycles after valid.
    foreach (d[i]) d[i] = 5;
    run_frame(2'd0, 5'd1, 8'h10, d, -1, 1'b0);

    // Four positions across the address wrap.
    d[0] = 3; d[1] = 7; d[2] = 1; d[3] = 5;
    run_frame(2'd1, 5'd4, 8'hFE, d, -1, 1'b0);

    // Timeout; the late done lands in IDLE and must be ignored.
    d[0] = TO_CYC;
    run_frame(2'd2, 5'd1, 8'h20, d, -1, 1'b0);

    // abort together with start in IDLE: nothing starts, error stays.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; cfg_mode = 2'd0;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort+start busy", int'(busy), 0);
    check("abort+start err_timeout kept", int'(err_timeout), 1);

    // Done on the last allowed cycle is accepted; next position times out.
    d[0] = TO_CYC - 1; d[1] = NEVER;
    run_frame(2'd3, 5'd2, 8'h30, d, -1, 1'b0);

    // Abort in the same cycle as done on the last position.
    foreach (d[i]) d[i] = 4;
    run_frame(2'd1, 5'd3, 8'h50, d, 2, 1'b0);
    check_idle_outputs("after abort");

    // Start re-pulsed during WAIT with another mode.
    d[0] = 8; d[1] = 2;
    run_frame(2'd2, 5'd2, 8'h60, d, -1, 1'b1);

    // Asynchronous reset while in LAT.
    mon_en = 1'b0;
    @(posedge clk); #1 start = 1'b1; cfg_mode = 2'd2; cfg_npos = 5'd3; cfg_base = 8'h40;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    check("oeb low in LAT before reset", int'(bus.dm_oeb), 0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check("async reset dm_addr",      int'(bus.dm_addr), 0);
    check("async reset arr_mode",     int'(bus.arr_mode), 0);
    check("async reset arr_position", int'(bus.arr_position), 0);
    check("async reset err_timeout",  int'(err_timeout), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete(); dq.delete();
    m_mode = 2'd0; m_pos = 0; m_err = 1'b0;
    @(posedge clk); #1 mon_en = 1'b1;
    foreach (d[i]) d[i] = 3;
    run_frame(2'd3, 5'd2, 8'h70, d, -1, 1'b0);

    // Randomised frames, npos 0 meaning 16, occasional aborts and late dones.
    for (int f = 0; f < 10; f++) begin
      logic [1:0] md;
      logic [4:0] np;
      int         n, ak;
      md = 2'($urandom_range(0, 3));
      np = 5'($urandom_range(0, 16));
      n  = (np == 5'd0) ? 16 : int'(np);
      foreach (d[i]) begin
        if ($urandom_range(0, 9) == 0) d[i] = TO_CYC - 1;
        else                           d[i] = int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 3) == 0) ak = int'($urandom_range(0, n - 1));
      else                           ak = -1;
      run_frame(md, np, 8'($urandom), d, ak, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
